stutter_trace_checker: RTL
==========================

# stutter_trace_checker

Downstream observer for a source/target code-block pair in the asynchronous hyperproperty case studies. It consumes the registered observable outputs `a`, `b` and `stutter` of a source program model and its optimized target model. It reduces each side to its stutter-free sequence of distinct observations and buffers each sequence in a small FIFO. It compares the two sequences pairwise and raises sticky verdict flags on the first divergence or on buffer overflow.

## Interface
Parameters:
- `DEPTH`, default 4: entries per side FIFO; power of two, ≥ 2.
- `LW`, derived `$clog2(DEPTH+1)`: width of the level outputs.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state.
- `src_a`, `src_b`  in  1 each  source observables.
- `src_stutter`  in  1  source stutter flag; 1 = source took no step this cycle.
- `tgt_a`, `tgt_b`  in  1 each  target observables.
- `tgt_stutter`  in  1  target stutter flag.
- `mismatch`  out  1  sticky; heads of both FIFOs differed.
- `overflow`  out  1  sticky; observation event arrived at a full FIFO.
- `ok`  out  1  high while in RUN.
- `src_level`, `tgt_level`  out  LW each  current FIFO occupancy.

## Operation
- Observation per side: `obs = {a,b}` (2 bits).
- Each side has a `last` register, reset to 2'b00, matching the code-block reset outputs.
- Event: a side produces an event when `stutter==0` and `obs != last`.
- On an event, `obs` is pushed and `last <= obs`.
- Repeated or stuttered values produce no event (stutter-insensitive reduction).
- Each FIFO is circular: write pointer, read pointer, and a count of 0..DEPTH. Pointers wrap modulo DEPTH.
- Compare: when both counts are > 0, the heads are compared combinationally.
  - Equal heads: both FIFOs pop at the edge.
  - Unequal heads: no pop; go to FAIL_MIS.
- Push and pop in the same cycle on one side is allowed. Count is unchanged and both pointers advance.
- Full FIFO with a same-cycle pop accepts the push; this is not an overflow.
- Full FIFO with a push and no pop: the event is dropped and the checker goes to FAIL_OVF.
- State machine (2 bits): RUN, FAIL_MIS, FAIL_OVF.
  - RUN → FAIL_MIS on a head mismatch.
  - RUN → FAIL_OVF on an overflow.
  - Mismatch and overflow in the same cycle: FAIL_MIS wins, and both `mismatch` and `overflow` are set.
  - FAIL states are terminal until `rst`.
  - In FAIL states, FIFOs, pointers, `last` and levels freeze.
- Outputs are registered:
  - `ok = (state==RUN)`.
  - `mismatch` is set on the RUN→FAIL_MIS edge.
  - `overflow` is set on any overflow condition seen in RUN.
- Reset values: `mismatch=0`, `overflow=0`, `ok=1`, `src_level=0`, `tgt_level=0`, state RUN, pointers 0, `last=2'b00`.
- `rst` asserted mid-operation clears everything immediately (asynchronously), including pending entries and sticky flags.

## Timing
- Inputs are sampled at posedge k. An event pushes at edge k, and the level reflects it after edge k.
- Heads written at edge k are compared during cycle k+1:
  - Matching pair: pops at edge k+1.
  - Mismatching pair: `mismatch=1`, `ok=0` after edge k+1.
- Minimum event-to-verdict latency: 2 edges from input sample to flag.
- Overflow flag: set after the edge that carries the dropped event.
- One side may lead the other by up to DEPTH unmatched observations; DEPTH+1 with no pop is an overflow.
- No handshake to the code blocks. The checker never back-pressures; stutter is driven externally.

## Test plan
- Reset then idle: hold all inputs 0 → `ok=1`, levels 0, no flags, for 20 cycles.
- Identical traces with different stutter: src emits {0,1},{1,1} on cycles 2,3; tgt emits the same on cycles 5,9, stuttering otherwise → `src_level` peaks at 2 and returns to 0 two edges after tgt's last event; `ok` stays 1.
- Repeated value: src holds {1,0} unstuttered for 6 cycles, tgt emits {1,0} once → exactly one event per side; pair pops; no flag.
- Divergence: src emits {1,0}, tgt emits {0,1} in the same cycle → `mismatch=1`, `ok=0` two edges after sampling; further inputs do not change the levels (1,1).
- Overflow with DEPTH=4: src emits alternating {1,0},{0,1} for 5 events with tgt stuttered → `overflow=1` after the 5th event's edge; `src_level=4` frozen. Full FIFO with a simultaneous matching pop → no overflow.
- Mid-run reset: assert `rst` asynchronously with levels at 3 and `mismatch=1` → all outputs return to reset values before the next edge; a subsequent identical trace passes.

Source files
------------

// File: rtl/stutter_trace_checker.sv
// Stutter-insensitive trace comparator for a source/target code-block pair.
// Each side is reduced to its distinct-observation sequence, buffered, and compared head-to-head.
module stutter_trace_checker #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src_a,
    input  logic          src_b,
    input  logic          src_stutter,
    input  logic          tgt_a,
    input  logic          tgt_b,
    input  logic          tgt_stutter,
    output logic          mismatch,
    output logic          overflow,
    output logic          ok,
    output logic [LW-1:0] src_level,
    output logic [LW-1:0] tgt_level
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] CNT_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] CNT_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] CNT_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FAIL_MIS = 2'b01,
        FAIL_OVF = 2'b10
    } state_t;

    // Index 0 is the source side, index 1 the target side.
    logic [1:0]    obs_s   [2];
    logic [1:0]    stut_s;
    logic [1:0]    last_q  [2];
    logic [1:0]    last_d  [2];
    logic [1:0]    mem_q   [2][DEPTH];
    logic [1:0]    mem_d   [2][DEPTH];
    logic [PW-1:0] wr_q    [2];
    logic [PW-1:0] wr_d    [2];
    logic [PW-1:0] rd_q    [2];
    logic [PW-1:0] rd_d    [2];
    logic [LW-1:0] cnt_q   [2];
    logic [LW-1:0] cnt_d   [2];
    logic [1:0]    ev_s;
    logic [1:0]    push_s;
    logic [1:0]    drop_s;
    state_t        state_q, state_d;
    logic          mismatch_q, mismatch_d;
    logic          overflow_q, overflow_d;
    logic          ok_q, ok_d;
    logic          run_s, both_s, heads_eq_s, pop_s, mis_s, ovf_s;

    assign obs_s[0] = {src_a, src_b};
    assign obs_s[1] = {tgt_a, tgt_b};
    assign stut_s   = {tgt_stutter, src_stutter};

    // A push into a full FIFO is only legal when the pair pops in the same cycle.
    always_comb begin
        run_s      = (state_q == RUN);
        both_s     = (cnt_q[0] != CNT_ZERO) && (cnt_q[1] != CNT_ZERO);
        heads_eq_s = (mem_q[0][rd_q[0]] == mem_q[1][rd_q[1]]);
        pop_s      = run_s && both_s && heads_eq_s;
        mis_s      = run_s && both_s && !heads_eq_s;
        ev_s       = 2'b00;
        push_s     = 2'b00;
        drop_s     = 2'b00;
        for (int s = 0; s < 2; s++) begin
            ev_s[s]   = !stut_s[s] && (obs_s[s] != last_q[s]);
            push_s[s] = run_s && ev_s[s] && ((cnt_q[s] != CNT_FULL) || pop_s);
            drop_s[s] = run_s && ev_s[s] && (cnt_q[s] == CNT_FULL) && !pop_s;
        end
        ovf_s = |drop_s;
    end

    // FIFO datapath next-state; everything holds outside RUN because push/pop are gated.
    always_comb begin
        last_d = last_q;
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        for (int s = 0; s < 2; s++) begin
            if (push_s[s]) begin
                mem_d[s][wr_q[s]] = obs_s[s];
                wr_d[s]           = wr_q[s] + PTR_ONE;
                last_d[s]         = obs_s[s];
            end else begin
                wr_d[s] = wr_q[s];
            end
            if (pop_s) begin
                rd_d[s] = rd_q[s] + PTR_ONE;
            end else begin
                rd_d[s] = rd_q[s];
            end
            case ({push_s[s], pop_s})
                2'b10:   cnt_d[s] = cnt_q[s] + CNT_ONE;
                2'b01:   cnt_d[s] = cnt_q[s] - CNT_ONE;
                default: cnt_d[s] = cnt_q[s];
            endcase
        end
    end

    // Verdict FSM: a mismatch takes priority over a simultaneous overflow.
    always_comb begin
        state_d    = state_q;
        mismatch_d = mismatch_q | mis_s;
        overflow_d = overflow_q | ovf_s;
        case (state_q)
            RUN: begin
                if (mis_s) begin
                    state_d = FAIL_MIS;
                end else if (ovf_s) begin
                    state_d = FAIL_OVF;
                end else begin
                    state_d = RUN;
                end
            end
            FAIL_MIS: state_d = FAIL_MIS;
            FAIL_OVF: state_d = FAIL_OVF;
            default:  state_d = FAIL_MIS;
        endcase
        ok_d = (state_d == RUN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
            ok_q       <= 1'b1;
            for (int s = 0; s < 2; s++) begin
                last_q[s] <= 2'b00;
                wr_q[s]   <= {PW{1'b0}};
                rd_q[s]   <= {PW{1'b0}};
                cnt_q[s]  <= CNT_ZERO;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[s][i] <= 2'b00;
                end
            end
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            overflow_q <= overflow_d;
            ok_q       <= ok_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign mismatch  = mismatch_q;
    assign overflow  = overflow_q;
    assign ok        = ok_q;
    assign src_level = cnt_q[0];
    assign tgt_level = cnt_q[1];
endmodule
